mouse_select_ctrl: RTL and testbench
====================================

MOUSE_SELECT_CTRL -- requirements
Module: mouse_select_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1023, maximum cycles move_req is held without move_ack before abort.
REQ-002 Parameter MAX_BLOCK_X, default 17, highest legal block column index.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 l_click  input  1  single-cycle left-click pulse from mouse interface.
REQ-006 mouse_inblock  input  1  high when pointer lies inside a legal block.
REQ-007 mouse_block_x  input  5  pointer block column.
REQ-008 mouse_block_y  input  3  pointer block row; 0-5 board, 6-7 hand.
REQ-009 my_turn  input  1  high while local player may act.
REQ-010 move_ack  input  1  game logic accepts the current move request.
REQ-011 sel_valid  output  1  a source block is currently selected (highlight enable).
REQ-012 sel_x  output  5  selected source column.
REQ-013 sel_y  output  3  selected source row.
REQ-014 move_req  output  1  move request, level, held until ack or timeout.
REQ-015 move_src_x / move_src_y  output  5 / 3  move source block.
REQ-016 move_dst_x / move_dst_y  output  5 / 3  move destination block.
REQ-017 move_err  output  1  single-cycle pulse on request timeout.
REQ-018 busy  output  1  high in state REQ.

Function
REQ-019 The block SHALL implement FSM states IDLE, PICKED, REQ; state encoded in registers, outputs registered.
REQ-020 A click is "legal" when l_click=1, mouse_inblock=1, mouse_block_x<=MAX_BLOCK_X, and my_turn=1.
REQ-021 IDLE: legal click SHALL latch sel_x/sel_y from pointer, set sel_valid=1 next cycle, go PICKED; all other clicks ignored.
REQ-022 PICKED: legal click on a block different from (sel_x,sel_y) SHALL latch destination, copy selection to move_src, assert move_req next cycle, go REQ.
REQ-023 PICKED: legal click on the same block SHALL clear sel_valid and return IDLE (deselect).
REQ-024 PICKED: l_click with mouse_inblock=0 or block_x>MAX_BLOCK_X SHALL clear sel_valid and return IDLE.
REQ-025 PICKED: my_turn=0 SHALL clear sel_valid and return IDLE next cycle, taking priority over a same-cycle click.
REQ-026 REQ: sel_valid SHALL remain 1, move_src/move_dst SHALL stay stable, all clicks ignored.
REQ-027 REQ: move_ack=1 SHALL drop move_req and sel_valid next cycle and return IDLE; move_ack outside REQ is ignored.
REQ-028 REQ: a 16-bit wait counter SHALL clear on REQ entry and increment each cycle without ack; when it reaches ACK_TIMEOUT, next cycle move_req=0, sel_valid=0, move_err=1 for one cycle, state IDLE.
REQ-029 Ack arriving on the same cycle the counter reaches ACK_TIMEOUT SHALL be treated as ack (no move_err).
REQ-030 my_turn falling in REQ SHALL NOT abort the request; only ack or timeout exit REQ.
REQ-031 Latency: click to sel_valid/move_req assertion SHALL be exactly one cycle.
REQ-032 move_src/move_dst SHALL hold their last values when not in REQ.

Reset
REQ-033 rst=1 SHALL, on the next rising edge, force IDLE and clear sel_valid, sel_x, sel_y, move_req, move_src_*, move_dst_*, move_err, busy, wait counter to 0, overriding any in-progress state including REQ.

Verification
REQ-034 my_turn=1, click block (3,2), then click (10,6) -> sel_valid=1 sel=(3,2) one cycle after first click; move_req=1 src=(3,2) dst=(10,6) one cycle after second; ack -> move_req=0, IDLE.
REQ-035 Click (5,1) twice -> sel_valid rises then falls, move_req never asserted.
REQ-036 In PICKED, click with mouse_inblock=0 -> sel_valid=0; click with block_x=18 in IDLE -> no change.
REQ-037 Enter REQ with ACK_TIMEOUT=8, never ack -> move_req drops and move_err pulses exactly 9 cycles after request assertion; ack on the timeout cycle -> no move_err.
REQ-038 In PICKED, drop my_turn coincident with a different-block click -> IDLE, no move_req; in REQ, drop my_turn -> move_req stays high.
REQ-039 Assert rst while in REQ -> all outputs 0 next cycle, subsequent ack ignored.

Source files
------------

// File: rtl/mouse_select_ctrl.sv
// mouse_select_ctrl
//   Turns mouse clicks into move requests. The first legal click picks a
//   source block and the second legal click on a different block picks the
//   destination. A move request is then held until the game logic acks it or
//   until ACK_TIMEOUT cycles pass without an ack.
//
// Parameters
//   ACK_TIMEOUT   wait-counter value at which an un-acked request aborts
//   MAX_BLOCK_X   highest legal block column index
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   l_click                   single-cycle left-click pulse
//   mouse_inblock             pointer is inside a legal block
//   mouse_block_x/_y          pointer block column / row (rows 6-7 = hand)
//   my_turn                   local player may act
//   move_ack                  game logic accepts the pending request
//   sel_valid, sel_x, sel_y   current source selection (highlight)
//   move_req                  level request, held until ack or timeout
//   move_src_x/_y             move source block
//   move_dst_x/_y             move destination block
//   move_err                  one-cycle pulse when a request times out
//   busy                      request outstanding (state REQ)
module mouse_select_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned MAX_BLOCK_X = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l_click,
  input  logic       mouse_inblock,
  input  logic [4:0] mouse_block_x,
  input  logic [2:0] mouse_block_y,
  input  logic       my_turn,
  input  logic       move_ack,
  output logic       sel_valid,
  output logic [4:0] sel_x,
  output logic [2:0] sel_y,
  output logic       move_req,
  output logic [4:0] move_src_x,
  output logic [2:0] move_src_y,
  output logic [4:0] move_dst_x,
  output logic [2:0] move_dst_y,
  output logic       move_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PICKED = 2'd1,
    REQ    = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(ACK_TIMEOUT);
  localparam logic [4:0]  MAX_X   = 5'(MAX_BLOCK_X);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;

  logic       sel_valid_nxt;
  logic [4:0] sel_x_nxt;
  logic [2:0] sel_y_nxt;
  logic       move_req_nxt;
  logic [4:0] move_src_x_nxt, move_dst_x_nxt;
  logic [2:0] move_src_y_nxt, move_dst_y_nxt;
  logic       move_err_nxt;
  logic       busy_nxt;

  logic in_range;
  logic legal_click;
  logic same_block;

  assign in_range    = mouse_inblock && (mouse_block_x <= MAX_X);
  assign legal_click = l_click && in_range && my_turn;
  assign same_block  = (mouse_block_x == sel_x) && (mouse_block_y == sel_y);

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    sel_valid_nxt  = sel_valid;
    sel_x_nxt      = sel_x;
    sel_y_nxt      = sel_y;
    move_req_nxt   = move_req;
    move_src_x_nxt = move_src_x;
    move_src_y_nxt = move_src_y;
    move_dst_x_nxt = move_dst_x;
    move_dst_y_nxt = move_dst_y;
    move_err_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (legal_click) begin
          sel_x_nxt     = mouse_block_x;
          sel_y_nxt     = mouse_block_y;
          sel_valid_nxt = 1'b1;
          state_nxt     = PICKED;
        end
      end

      PICKED: begin
        // Losing the turn wins over any click in the same cycle.
        if (!my_turn) begin
          sel_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (l_click) begin
          if (in_range && !same_block) begin
            move_src_x_nxt = sel_x;
            move_src_y_nxt = sel_y;
            move_dst_x_nxt = mouse_block_x;
            move_dst_y_nxt = mouse_block_y;
            move_req_nxt   = 1'b1;
            wait_cnt_nxt   = '0;
            state_nxt      = REQ;
          end else begin
            // Same block (deselect) or click outside the board.
            sel_valid_nxt = 1'b0;
            state_nxt     = IDLE;
          end
        end
      end

      REQ: begin
        // Ack is tested first so an ack on the timeout cycle is not an error.
        if (move_ack) begin
          move_req_nxt  = 1'b0;
          sel_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (wait_cnt == TIMEOUT) begin
          move_req_nxt  = 1'b0;
          sel_valid_nxt = 1'b0;
          move_err_nxt  = 1'b1;
          state_nxt     = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end

      default: begin
        state_nxt     = IDLE;
        sel_valid_nxt = 1'b0;
        move_req_nxt  = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      sel_valid  <= 1'b0;
      sel_x      <= '0;
      sel_y      <= '0;
      move_req   <= 1'b0;
      move_src_x <= '0;
      move_src_y <= '0;
      move_dst_x <= '0;
      move_dst_y <= '0;
      move_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      sel_valid  <= sel_valid_nxt;
      sel_x      <= sel_x_nxt;
      sel_y      <= sel_y_nxt;
      move_req   <= move_req_nxt;
      move_src_x <= move_src_x_nxt;
      move_src_y <= move_src_y_nxt;
      move_dst_x <= move_dst_x_nxt;
      move_dst_y <= move_dst_y_nxt;
      move_err   <= move_err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mouse_select_ctrl.sv
// Testbench for mouse_select_ctrl (ACK_TIMEOUT overridden to 8).
// Each cycle's inputs are driven together with the outputs expected after the
// next rising edge; the expectation is queued and checked 1 ns after the edge.
module tb_mouse_select_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       l_click;
  logic       mouse_inblock;
  logic [4:0] mouse_block_x;
  logic [2:0] mouse_block_y;
  logic       my_turn;
  logic       move_ack;
  logic       sel_valid;
  logic [4:0] sel_x;
  logic [2:0] sel_y;
  logic       move_req;
  logic [4:0] move_src_x, move_dst_x;
  logic [2:0] move_src_y, move_dst_y;
  logic       move_err;
  logic       busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [27:0] exp_q[$];

  mouse_select_ctrl #(
    .ACK_TIMEOUT(8),
    .MAX_BLOCK_X(17)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .l_click      (l_click),
    .mouse_inblock(mouse_inblock),
    .mouse_block_x(mouse_block_x),
    .mouse_block_y(mouse_block_y),
    .my_turn      (my_turn),
    .move_ack     (move_ack),
    .sel_valid    (sel_valid),
    .sel_x        (sel_x),
    .sel_y        (sel_y),
    .move_req     (move_req),
    .move_src_x   (move_src_x),
    .move_src_y   (move_src_y),
    .move_dst_x   (move_dst_x),
    .move_dst_y   (move_dst_y),
    .move_err     (move_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Output vector: {sel_valid, sel_x, sel_y, move_req, src_x, src_y, dst_x, dst_y, move_err, busy}
  function automatic logic [27:0] ev(input logic sv, input int sx, input int sy,
                                     input logic mr, input int srx, input int sry,
                                     input int dx, input int dy,
                                     input logic er, input logic bz);
    return {sv, 5'(sx), 3'(sy), mr, 5'(srx), 3'(sry), 5'(dx), 3'(dy), er, bz};
  endfunction

  task automatic check(input string tag, input logic [27:0] act, input logic [27:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, check them.
  task automatic cyc(input string tag, input logic r, input logic clk_in,
                     input logic inb, input int bx, input int by,
                     input logic turn, input logic ack, input logic [27:0] exp);
    rst           = r;
    l_click       = clk_in;
    mouse_inblock = inb;
    mouse_block_x = 5'(bx);
    mouse_block_y = 3'(by);
    my_turn       = turn;
    move_ack      = ack;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, {sel_valid, sel_x, sel_y, move_req, move_src_x, move_src_y,
                move_dst_x, move_dst_y, move_err, busy}, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; l_click = 1'b0; mouse_inblock = 1'b0; mouse_block_x = '0;
    mouse_block_y = '0; my_turn = 1'b0; move_ack = 1'b0;

    // Reset
    cyc("reset0", 1, 0, 0, 0, 0, 0, 0, ev(0,0,0, 0,0,0,0,0, 0,0));
    cyc("reset1", 1, 0, 0, 0, 0, 0, 0, ev(0,0,0, 0,0,0,0,0, 0,0));

    // Pick (3,2), move to (10,6), ack
    cyc("pick32",  0, 1, 1, 3, 2, 1, 0, ev(1,3,2, 0,0,0,0,0, 0,0));
    cyc("hold32",  0, 0, 0, 0, 0, 1, 0, ev(1,3,2, 0,0,0,0,0, 0,0));
    cyc("req106",  0, 1, 1, 10, 6, 1, 0, ev(1,3,2, 1,3,2,10,6, 0,1));
    cyc("reqhold", 0, 1, 1, 4, 4, 1, 0, ev(1,3,2, 1,3,2,10,6, 0,1));
    cyc("ack",     0, 0, 0, 0, 0, 1, 1, ev(0,3,2, 0,3,2,10,6, 0,0));
    cyc("ackidle", 0, 0, 0, 0, 0, 1, 1, ev(0,3,2, 0,3,2,10,6, 0,0));

    // Same block twice deselects
    cyc("pick51",  0, 1, 1, 5, 1, 1, 0, ev(1,5,1, 0,3,2,10,6, 0,0));
    cyc("desel51", 0, 1, 1, 5, 1, 1, 0, ev(0,5,1, 0,3,2,10,6, 0,0));

    // Click outside block in PICKED; out-of-range x in IDLE and PICKED
    cyc("pick43",  0, 1, 1, 4, 3, 1, 0, ev(1,4,3, 0,3,2,10,6, 0,0));
    cyc("outblk",  0, 1, 0, 7, 7, 1, 0, ev(0,4,3, 0,3,2,10,6, 0,0));
    cyc("x18idle", 0, 1, 1, 18, 0, 1, 0, ev(0,4,3, 0,3,2,10,6, 0,0));
    cyc("pick10",  0, 1, 1, 1, 0, 1, 0, ev(1,1,0, 0,3,2,10,6, 0,0));
    cyc("x18pick", 0, 1, 1, 18, 0, 1, 0, ev(0,1,0, 0,3,2,10,6, 0,0));
    cyc("noturn",  0, 1, 1, 6, 6, 0, 0, ev(0,1,0, 0,3,2,10,6, 0,0));

    // Turn loss wins over a same-cycle click on a different block
    cyc("pick22",  0, 1, 1, 2, 2, 1, 0, ev(1,2,2, 0,3,2,10,6, 0,0));
    cyc("turnlost",0, 1, 1, 9, 4, 0, 0, ev(0,2,2, 0,3,2,10,6, 0,0));
    cyc("turnidle",0, 0, 0, 0, 0, 1, 0, ev(0,2,2, 0,3,2,10,6, 0,0));

    // Timeout: destination at MAX_BLOCK_X; my_turn low and clicks in REQ ignored
    cyc("pick00",  0, 1, 1, 0, 0, 1, 0, ev(1,0,0, 0,3,2,10,6, 0,0));
    cyc("req175",  0, 1, 1, 17, 5, 1, 0, ev(1,0,0, 1,0,0,17,5, 0,1));
    for (int i = 1; i <= 8; i++)
      cyc($sformatf("towait%0d", i), 0, 1, 1, 3, 3, 0, 0, ev(1,0,0, 1,0,0,17,5, 0,1));
    cyc("toerr",   0, 0, 0, 0, 0, 1, 0, ev(0,0,0, 0,0,0,17,5, 1,0));
    cyc("toerrend",0, 0, 0, 0, 0, 1, 0, ev(0,0,0, 0,0,0,17,5, 0,0));

    // Ack on the timeout cycle: no error
    cyc("pick11",  0, 1, 1, 1, 1, 1, 0, ev(1,1,1, 0,0,0,17,5, 0,0));
    cyc("req22",   0, 1, 1, 2, 2, 1, 0, ev(1,1,1, 1,1,1,2,2, 0,1));
    for (int i = 1; i <= 8; i++)
      cyc($sformatf("ackwait%0d", i), 0, 0, 0, 0, 0, 1, 0, ev(1,1,1, 1,1,1,2,2, 0,1));
    cyc("acklate", 0, 0, 0, 0, 0, 1, 1, ev(0,1,1, 0,1,1,2,2, 0,0));
    cyc("acklate1",0, 0, 0, 0, 0, 1, 0, ev(0,1,1, 0,1,1,2,2, 0,0));

    // Reset while in REQ, then a stray ack
    cyc("pick67",  0, 1, 1, 6, 7, 1, 0, ev(1,6,7, 0,1,1,2,2, 0,0));
    cyc("req80",   0, 1, 1, 8, 0, 1, 0, ev(1,6,7, 1,6,7,8,0, 0,1));
    cyc("rstreq",  1, 0, 0, 0, 0, 1, 0, ev(0,0,0, 0,0,0,0,0, 0,0));
    cyc("rstack",  0, 0, 0, 0, 0, 1, 1, ev(0,0,0, 0,0,0,0,0, 0,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
